// File: rtl/axil_reg_bridge_if.sv
// AXI-Lite bus bundle used between an interconnect (master) and axil_reg_bridge (slave).
//   aw*/w*/b* : write address, write data and write response channels
//   ar*/r*    : read address and read data channels
// awprot/arprot are carried for completeness; the bridge ignores them.
interface axil_reg_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bridge.sv
// AXI-Lite slave to register-bank bridge.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   axil        : AXI-Lite slave side (axil_reg_bridge_if.slave)
//   reg_w*      : register write port; reg_wen pulses one cycle per issued write,
//                 reg_werror is the bank's same-cycle error flag for that write
//   reg_r*      : register read port; reg_ren pulses per in-range read, reg_rdata and
//                 reg_rerror are valid RD_LATENCY cycles later
// Writes: AW and W each land in a 1-entry hold register and issue together, one per cycle
// when streaming, as long as the B FIFO has room. Reads: a credit counter bounds the
// outstanding reads to RESP_DEPTH so the R FIFO can never overflow; every read, including
// out-of-range ones, walks the same fixed-latency pipeline so responses stay in AR order.
module axil_reg_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RESP_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  axil_reg_bridge_if.slave          axil,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
  output logic                      reg_wen,
  input  logic                      reg_werror,
  output logic [REG_ADDR_WIDTH-1:0] reg_raddr,
  output logic                      reg_ren,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_rerror
);
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = $clog2(RESP_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned REntW = DATA_WIDTH + 2;
  localparam logic [CntW-1:0] DepthCnt = CntW'(RESP_DEPTH);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (REG_ADDR_WIDTH + 2)) != '0;
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
    return a[REG_ADDR_WIDTH+1:2];
  endfunction

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic                      aw_held_q, aw_held_d;
  logic                      aw_oor_q, aw_oor_d;
  logic [REG_ADDR_WIDTH-1:0] aw_word_q, aw_word_d;
  logic                      w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [StrbW-1:0]          w_strb_q, w_strb_d;

  logic [1:0]                b_mem_q [RESP_DEPTH];
  logic [1:0]                b_mem_d [RESP_DEPTH];
  logic [PtrW-1:0]           b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic [CntW-1:0]           b_count_q, b_count_d;

  logic bvalid_int, b_pop, wr_issue, awready_int, wready_int, aw_hs, w_hs, wen_int;
  logic [1:0] b_push_resp;

  assign bvalid_int  = (b_count_q != '0);
  assign b_pop       = bvalid_int && axil.bready;
  // A same-cycle B pop frees the slot this issue needs, keeping full-rate streaming.
  assign wr_issue    = aw_held_q && w_held_q && ((b_count_q < DepthCnt) || b_pop);
  assign awready_int = !aw_held_q || wr_issue;
  assign wready_int  = !w_held_q || wr_issue;
  assign aw_hs       = axil.awvalid && awready_int;
  assign w_hs        = axil.wvalid && wready_int;
  assign wen_int     = wr_issue && !aw_oor_q && (w_strb_q != '0);
  // A write that never reaches the bank cannot be blamed on it, so werror is ignored then.
  assign b_push_resp = aw_oor_q              ? RespDecErr :
                       (wen_int && reg_werror) ? RespSlvErr : RespOkay;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_oor_d  = aw_oor_q;
    aw_word_d = aw_word_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (wr_issue) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_oor_d  = addr_oor(axil.awaddr);
      aw_word_d = word_addr(axil.awaddr);
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = axil.wdata;
      w_strb_d = axil.wstrb;
    end
  end

  always_comb begin
    b_mem_d  = b_mem_q;
    b_wptr_d = b_wptr_q;
    b_rptr_d = b_rptr_q;
    if (wr_issue) begin
      b_mem_d[b_wptr_q] = b_push_resp;
      b_wptr_d          = b_wptr_q + 1'b1;
    end
    if (b_pop) begin
      b_rptr_d = b_rptr_q + 1'b1;
    end
    b_count_d = b_count_q + CntW'(wr_issue) - CntW'(b_pop);
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic                      ar_vld_q, ar_vld_d;
  logic                      ar_oor_q, ar_oor_d;
  logic [REG_ADDR_WIDTH-1:0] ar_word_q, ar_word_d;
  logic [RD_LATENCY-1:0]     lat_vld_q, lat_vld_d;
  logic [RD_LATENCY-1:0]     lat_oor_q, lat_oor_d;
  logic [CntW-1:0]           rd_cnt_q, rd_cnt_d;

  logic [REntW-1:0]          r_mem_q [RESP_DEPTH];
  logic [REntW-1:0]          r_mem_d [RESP_DEPTH];
  logic [PtrW-1:0]           r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
  logic [CntW-1:0]           r_count_q, r_count_d;

  logic arready_int, ar_hs, rvalid_int, r_pop, r_push, ren_int;
  logic [REntW-1:0] r_push_ent;

  assign arready_int = (rd_cnt_q < DepthCnt);
  assign ar_hs       = axil.arvalid && arready_int;
  assign rvalid_int  = (r_count_q != '0);
  assign r_pop       = rvalid_int && axil.rready;
  assign ren_int     = ar_vld_q && !ar_oor_q;
  assign r_push      = lat_vld_q[RD_LATENCY-1];
  assign r_push_ent  = lat_oor_q[RD_LATENCY-1] ? {RespDecErr, {DATA_WIDTH{1'b0}}} :
                       reg_rerror               ? {RespSlvErr, reg_rdata} :
                                                  {RespOkay, reg_rdata};

  always_comb begin
    ar_vld_d  = ar_hs;
    ar_oor_d  = ar_oor_q;
    ar_word_d = ar_word_q;
    if (ar_hs) begin
      ar_oor_d  = addr_oor(axil.araddr);
      ar_word_d = word_addr(axil.araddr);
    end
    // Delay line tracks which cycle the bank's read data belongs to a pending read.
    lat_vld_d    = lat_vld_q;
    lat_oor_d    = lat_oor_q;
    lat_vld_d[0] = ar_vld_q;
    lat_oor_d[0] = ar_oor_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      lat_vld_d[i] = lat_vld_q[i-1];
      lat_oor_d[i] = lat_oor_q[i-1];
    end
    rd_cnt_d = rd_cnt_q + CntW'(ar_hs) - CntW'(r_pop);
  end

  always_comb begin
    r_mem_d  = r_mem_q;
    r_wptr_d = r_wptr_q;
    r_rptr_d = r_rptr_q;
    if (r_push) begin
      r_mem_d[r_wptr_q] = r_push_ent;
      r_wptr_d          = r_wptr_q + 1'b1;
    end
    if (r_pop) begin
      r_rptr_d = r_rptr_q + 1'b1;
    end
    r_count_d = r_count_q + CntW'(r_push) - CntW'(r_pop);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_oor_q  <= 1'b0;
      aw_word_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_mem_q   <= '{default: '0};
      b_wptr_q  <= '0;
      b_rptr_q  <= '0;
      b_count_q <= '0;
      ar_vld_q  <= 1'b0;
      ar_oor_q  <= 1'b0;
      ar_word_q <= '0;
      lat_vld_q <= '0;
      lat_oor_q <= '0;
      rd_cnt_q  <= '0;
      r_mem_q   <= '{default: '0};
      r_wptr_q  <= '0;
      r_rptr_q  <= '0;
      r_count_q <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_oor_q  <= aw_oor_d;
      aw_word_q <= aw_word_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_mem_q   <= b_mem_d;
      b_wptr_q  <= b_wptr_d;
      b_rptr_q  <= b_rptr_d;
      b_count_q <= b_count_d;
      ar_vld_q  <= ar_vld_d;
      ar_oor_q  <= ar_oor_d;
      ar_word_q <= ar_word_d;
      lat_vld_q <= lat_vld_d;
      lat_oor_q <= lat_oor_d;
      rd_cnt_q  <= rd_cnt_d;
      r_mem_q   <= r_mem_d;
      r_wptr_q  <= r_wptr_d;
      r_rptr_q  <= r_rptr_d;
      r_count_q <= r_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all forced low while rst is high, since reset only takes effect at the edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    axil.bvalid  = 1'b0;
    axil.bresp   = 2'b00;
    axil.arready = 1'b0;
    axil.rvalid  = 1'b0;
    axil.rresp   = 2'b00;
    axil.rdata   = '0;
    reg_waddr    = '0;
    reg_wdata    = '0;
    reg_wstrb    = '0;
    reg_wen      = 1'b0;
    reg_raddr    = '0;
    reg_ren      = 1'b0;
    if (!rst) begin
      axil.awready = awready_int;
      axil.wready  = wready_int;
      axil.bvalid  = bvalid_int;
      axil.bresp   = b_mem_q[b_rptr_q];
      axil.arready = arready_int;
      axil.rvalid  = rvalid_int;
      axil.rresp   = r_mem_q[r_rptr_q][REntW-1:DATA_WIDTH];
      axil.rdata   = r_mem_q[r_rptr_q][DATA_WIDTH-1:0];
      reg_waddr    = aw_word_q;
      reg_wdata    = w_data_q;
      reg_wstrb    = w_strb_q;
      reg_wen      = wen_int;
      reg_raddr    = ar_word_q;
      reg_ren      = ren_int;
    end
  end
endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
- Parametrised AXI-Lite slave to register-bank bridge. Successor to the single-outstanding AXI-Lite slave interface.
- Adds the following over that block:
  - independent write and read register ports;
  - configurable register read latency;
  - multiple outstanding transactions, buffered in response FIFOs;
  - address-range decode returning DECERR;
  - single-cycle write throughput.
- Sits between the interconnect and peripheral register files (UART and later blocks).

Parameters:
- DATA_WIDTH, 32, AXI and register data width (32 or 64).
- ADDR_WIDTH, 32, AXI address width.
- REG_ADDR_WIDTH, 4, word-address width of the register bank. Bank covers 2^REG_ADDR_WIDTH words.
- RD_LATENCY, 1, cycles from reg_ren to valid reg_rdata/reg_rerror. Legal range 1..4.
- RESP_DEPTH, 2, maximum outstanding responses per direction. Power of 2, at least 2.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- awaddr, input, ADDR_WIDTH, write address.
- awprot, input, 3, ignored.
- awvalid, input, 1, write address valid.
- awready, output, 1, write address ready.
- wdata, input, DATA_WIDTH, write data.
- wstrb, input, DATA_WIDTH/8, write byte strobes.
- wvalid, input, 1, write data valid.
- wready, output, 1, write data ready.
- bresp, output, 2, write response.
- bvalid, output, 1, write response valid.
- bready, input, 1, write response ready.
- araddr, input, ADDR_WIDTH, read address.
- arprot, input, 3, ignored.
- arvalid, input, 1, read address valid.
- arready, output, 1, read address ready.
- rdata, output, DATA_WIDTH, read data.
- rresp, output, 2, read response.
- rvalid, output, 1, read data valid.
- rready, input, 1, read data ready.
- reg_waddr, output, REG_ADDR_WIDTH, register write word address.
- reg_wdata, output, DATA_WIDTH, register write data.
- reg_wstrb, output, DATA_WIDTH/8, register write strobes.
- reg_wen, output, 1, register write strobe.
- reg_werror, input, 1, same-cycle error flag for the write at reg_waddr.
- reg_raddr, output, REG_ADDR_WIDTH, register read word address.
- reg_ren, output, 1, register read strobe.
- reg_rdata, input, DATA_WIDTH, read data, valid RD_LATENCY cycles after reg_ren.
- reg_rerror, input, 1, read error flag, valid with reg_rdata.

Behaviour:
- Reset (rst high, synchronous):
  - clears all state, FIFOs, hold registers, in-flight reads and credit counters;
  - during reset all outputs are 0, including awready/wready/arready;
  - first cycle after reset: awready=wready=arready=1, and bvalid=rvalid=0.
- Reset mid-transaction: the transaction is discarded. No B or R response is ever produced for it.
- Address decode:
  - word address = addr[REG_ADDR_WIDTH+1:2]; addr[1:0] are ignored;
  - out of range when addr[ADDR_WIDTH-1:REG_ADDR_WIDTH+2] != 0;
  - response codes: OKAY=00, SLVERR=10, DECERR=11.
- Write path, address/data capture:
  - AW and W are captured into separate 1-entry hold registers (aw_held, w_held);
  - awready = !aw_held || wr_issue; wready = !w_held || wr_issue.
- Write path, issue:
  - wr_issue = aw_held && w_held && (b_count < RESP_DEPTH || (bvalid && bready));
  - in the issue cycle, reg_wen=1 for exactly that cycle, unless the address is out of range or wstrb==0;
  - reg_waddr/reg_wdata/reg_wstrb are driven from the hold registers;
  - both holds clear in the issue cycle. With both channels streaming, writes sustain 1 per cycle.
- Write path, response:
  - response pushed to the B FIFO in the issue cycle;
  - bresp = DECERR if out of range, else SLVERR if reg_werror, else OKAY;
  - a wstrb==0 in-range write gives OKAY with no reg_wen;
  - bvalid = B FIFO non-empty; bresp is held stable while bvalid && !bready.
- Write path, latency: issue is the cycle after the later of the AW/W handshakes. bvalid is asserted the cycle after issue.
- Read path, credits:
  - rd_cnt counts accepted but not yet R-handshaken reads; arready = rd_cnt < RESP_DEPTH;
  - AR handshake and R handshake in the same cycle leave rd_cnt unchanged;
  - the R FIFO therefore never overflows.
- Read path, pipeline:
  - AR handshake at cycle T registers the address;
  - cycle T+1: reg_ren=1 and reg_raddr valid (suppressed if out of range);
  - cycle T+1+RD_LATENCY: reg_rdata/reg_rerror captured into the R FIFO;
  - cycle T+2+RD_LATENCY: rvalid asserted, if the FIFO was empty;
  - back-to-back AR handshakes issue reg_ren on consecutive cycles.
- Read path, out-of-range reads: travel the same pipeline to preserve ordering, with rdata=0 and rresp=DECERR.
- Read path, responses:
  - rresp = SLVERR if reg_rerror, else OKAY;
  - responses return strictly in AR order;
  - rdata/rresp are held stable while rvalid && !rready.
- Concurrency:
  - read and write paths are fully independent;
  - reg_wen and reg_ren may assert in the same cycle, including to the same address;
  - that ordering is defined by the register bank.

Test Plan:
- AW+W same cycle (0x8, 0xDEADBEEF, strb 0xF) -> reg_wen one cycle later, reg_waddr=2, reg_wdata=0xDEADBEEF; next cycle bvalid=1, bresp=00.
- W (0x12345678) 3 cycles before AW (0x4) -> wready=0 while held; reg_wen the cycle after the AW handshake, reg_waddr=1; bresp=00.
- Read 0x100 with REG_ADDR_WIDTH=4 -> reg_ren never asserted; rvalid at T+3 (RD_LATENCY=1), rdata=0, rresp=11.
- RD_LATENCY=2, RESP_DEPTH=2, 4 reads (0x0, 0x4, 0x8, 0xC), rready=0:
  - arready drops after 2 accepts;
  - raise rready -> remaining reads accepted;
  - 4 R beats in address order with bank data.
- Write to 0xC with reg_werror=1 -> bresp=10; a following write with reg_werror=0 -> bresp=00.
- Assert rst for 1 cycle with a read in flight and 2 B responses pending:
  - next cycle bvalid=rvalid=0, awready=wready=arready=1;
  - no stale responses afterwards.
